// File: rtl/lzc_normalizer_pipe_if.sv
// Handshake and result bus for the leading-zero-count normalizer pipeline.
interface lzc_normalizer_pipe_if #(
    parameter int WIDTH = 25,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [CW-1:0]    out_lzc;
    logic [WIDTH-1:0] out_norm;
    logic             out_zero;

    // Producer/consumer side
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_onehot, out_lzc, out_norm, out_zero
    );

    // Pipeline side
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_onehot, out_lzc, out_norm, out_zero
    );
endinterface

// File: rtl/lzc_normalizer_pipe.sv
// Two-stage leading-zero counter / normalizer.
// S1 resolves the highest set bit inside each GROUP-bit slice; S2 picks the
// highest non-empty slice, builds the full count and shifts the operand.
// The interface instance must be built with the same WIDTH.
module lzc_normalizer_pipe #(
    parameter int WIDTH = 25,
    parameter int GROUP = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lzc_normalizer_pipe_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int NG  = (WIDTH + GROUP - 1) / GROUP;
    // Operand is padded with zeros at the bottom so every slice is GROUP wide;
    // the padding can never be set, which makes the lowest slice act narrower.
    localparam int PW  = NG * GROUP;
    localparam int LCW = $clog2(GROUP);

    logic                      s1_vld, s2_vld;
    logic                      s2_en, s1_en, accept;
    logic [PW-1:0]             pad;
    logic [PW-1:0]             s1_oh_d, s1_oh;
    logic [NG-1:0]             s1_any_d, s1_any;
    logic [NG-1:0][LCW-1:0]    s1_llzc_d, s1_llzc;
    logic [WIDTH-1:0]          s1_data;
    logic [PW-1:0]             oh_pad;
    logic [WIDTH-1:0]          oh_d, norm_d;
    logic [CW-1:0]             lzc_d;
    logic                      zero_d;
    logic [WIDTH-1:0]          out_onehot_q, out_norm_q;
    logic [CW-1:0]             out_lzc_q;
    logic                      out_zero_q;

    // S2 takes new data when empty or draining; S1 when empty or moving on.
    assign s2_en  = ~s2_vld | bus.out_ready;
    assign s1_en  = ~s1_vld | s2_en;
    assign bus.in_ready = ~bus.flush & s1_en;
    assign accept = bus.in_valid & bus.in_ready;
    assign pad    = PW'(bus.in_data) << (PW - WIDTH);

    // S1: per-slice priority encode, scanning each slice from its MSB.
    always_comb begin
        s1_oh_d   = '0;
        s1_any_d  = '0;
        s1_llzc_d = '0;
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < GROUP; i++) begin
                if (!s1_any_d[g] && pad[PW-1-g*GROUP-i]) begin
                    s1_oh_d[PW-1-g*GROUP-i] = 1'b1;
                    s1_any_d[g]             = 1'b1;
                    s1_llzc_d[g]            = LCW'(i);
                end
            end
        end
    end

    // S2: first non-empty slice wins; slices below it are masked off.
    always_comb begin
        oh_pad = '0;
        lzc_d  = CW'(WIDTH);
        zero_d = 1'b1;
        for (int g = 0; g < NG; g++) begin
            if (zero_d && s1_any[g]) begin
                zero_d = 1'b0;
                lzc_d  = CW'(g * GROUP) + CW'(s1_llzc[g]);
                oh_pad[PW-1-g*GROUP -: GROUP] = s1_oh[PW-1-g*GROUP -: GROUP];
            end
        end
    end

    // A zero operand yields lzc=WIDTH, which shifts everything out.
    assign oh_d   = WIDTH'(oh_pad >> (PW - WIDTH));
    assign norm_d = s1_data << lzc_d;

    // Stage valid flags; flush overrides any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (bus.flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (s2_en) s2_vld <= s1_vld;
            if (s1_en) s1_vld <= bus.in_valid;
        end
    end

    // Stage data; loads are gated only by the handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_oh        <= '0;
            s1_any       <= '0;
            s1_llzc      <= '0;
            s1_data      <= '0;
            out_onehot_q <= '0;
            out_lzc_q    <= '0;
            out_norm_q   <= '0;
            out_zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                s1_oh   <= s1_oh_d;
                s1_any  <= s1_any_d;
                s1_llzc <= s1_llzc_d;
                s1_data <= bus.in_data;
            end
            if (s2_en && s1_vld && !bus.flush) begin
                out_onehot_q <= oh_d;
                out_lzc_q    <= lzc_d;
                out_norm_q   <= norm_d;
                out_zero_q   <= zero_d;
            end
        end
    end

    assign bus.out_valid  = s2_vld;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_lzc    = out_lzc_q;
    assign bus.out_norm   = out_norm_q;
    assign bus.out_zero   = out_zero_q;
endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
// Bench: a 25/8 instance for directed steps, a 13/4 instance for random traffic.
module tb_lzc_normalizer_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lzc_normalizer_pipe_if #(.WIDTH(25)) ia ();
    lzc_normalizer_pipe_if #(.WIDTH(13)) ib ();

    lzc_normalizer_pipe #(.WIDTH(25), .GROUP(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    lzc_normalizer_pipe #(.WIDTH(13), .GROUP(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        logic [63:0] oh;
        logic [63:0] lzc;
        logic [63:0] norm;
        logic [63:0] zero;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t hold_a, hold_b;
    bit   stall_a, stall_b;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: linear scan from the MSB down.
    function automatic exp_t model(input logic [63:0] d, input int w);
        exp_t e;
        e.oh = '0; e.lzc = 64'(w); e.norm = '0; e.zero = 64'd1;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i] && e.zero[0]) begin
                e.zero = 64'd0;
                e.oh   = 64'd1 << i;
                e.lzc  = 64'(w - 1 - i);
                e.norm = (d << (w - 1 - i)) & ((64'd1 << w) - 64'd1);
            end
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            cmp("a_rst_ov", 64'(ia.out_valid), 64'd0);
            cmp("b_rst_ov", 64'(ib.out_valid), 64'd0);
            qa.delete(); qb.delete();
            stall_a = 1'b0; stall_b = 1'b0;
        end else begin
            if (stall_a) begin
                cmp("a_hold_oh",   64'(ia.out_onehot), hold_a.oh);
                cmp("a_hold_lzc",  64'(ia.out_lzc),    hold_a.lzc);
                cmp("a_hold_norm", 64'(ia.out_norm),   hold_a.norm);
                cmp("a_hold_zero", 64'(ia.out_zero),   hold_a.zero);
            end
            if (ia.out_valid && ia.out_ready && !ia.flush) begin
                if (qa.size() == 0) cmp("a_unexpected_out", 64'(ia.out_valid), 64'd0);
                else begin
                    e = qa.pop_front();
                    cmp("a_oh",   64'(ia.out_onehot), e.oh);
                    cmp("a_lzc",  64'(ia.out_lzc),    e.lzc);
                    cmp("a_norm", 64'(ia.out_norm),   e.norm);
                    cmp("a_zero", 64'(ia.out_zero),   e.zero);
                end
            end
            if (ia.flush) qa.delete();
            if (ia.in_valid && ia.in_ready) qa.push_back(model(64'(ia.in_data), 25));
            stall_a = ia.out_valid && !ia.out_ready && !ia.flush;
            hold_a  = '{64'(ia.out_onehot), 64'(ia.out_lzc), 64'(ia.out_norm), 64'(ia.out_zero)};

            if (stall_b) begin
                cmp("b_hold_oh",   64'(ib.out_onehot), hold_b.oh);
                cmp("b_hold_lzc",  64'(ib.out_lzc),    hold_b.lzc);
                cmp("b_hold_norm", 64'(ib.out_norm),   hold_b.norm);
                cmp("b_hold_zero", 64'(ib.out_zero),   hold_b.zero);
            end
            if (ib.out_valid && ib.out_ready && !ib.flush) begin
                if (qb.size() == 0) cmp("b_unexpected_out", 64'(ib.out_valid), 64'd0);
                else begin
                    e = qb.pop_front();
                    cmp("b_oh",   64'(ib.out_onehot), e.oh);
                    cmp("b_lzc",  64'(ib.out_lzc),    e.lzc);
                    cmp("b_norm", 64'(ib.out_norm),   e.norm);
                    cmp("b_zero", 64'(ib.out_zero),   e.zero);
                end
            end
            if (ib.flush) qb.delete();
            if (ib.in_valid && ib.in_ready) qb.push_back(model(64'(ib.in_data), 13));
            stall_b = ib.out_valid && !ib.out_ready && !ib.flush;
            hold_b  = '{64'(ib.out_onehot), 64'(ib.out_lzc), 64'(ib.out_norm), 64'(ib.out_zero)};
        end
        @(posedge clk);
        #1;
    endtask

    logic [24:0] bnd_a [3];
    logic [12:0] bnd_b [3];
    logic [24:0] bp    [4];
    int k, nacc, cyc;

    initial begin
        bnd_a = '{25'h1FFFFFF, 25'h0000001, 25'h0000000};
        bnd_b = '{13'h1FFF, 13'h0001, 13'h0000};
        bp    = '{25'h0ABCDEF, 25'h0000F00, 25'h0800000, 25'h0000003};
        rst_n = 1'b0;
        ia.flush = 0; ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 1;
        ib.flush = 0; ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 1;

        // Reset state, before any clock edge
        #3;
        cmp("rst_ov",   64'(ia.out_valid),  64'd0);
        cmp("rst_oh",   64'(ia.out_onehot), 64'd0);
        cmp("rst_lzc",  64'(ia.out_lzc),    64'd0);
        cmp("rst_norm", 64'(ia.out_norm),   64'd0);
        cmp("rst_zero", 64'(ia.out_zero),   64'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        #1 cmp("rst_in_ready", 64'(ia.in_ready), 64'd1);

        // Single operand, latency 2
        ia.in_valid = 1; ia.in_data = 25'h0000100;
        tick();
        ia.in_valid = 0;
        cmp("lat_s1", 64'(ia.out_valid), 64'd0);
        tick();
        cmp("lat_s2",   64'(ia.out_valid),  64'd1);
        cmp("one_oh",   64'(ia.out_onehot), 64'h0000100);
        cmp("one_lzc",  64'(ia.out_lzc),    64'd16);
        cmp("one_norm", 64'(ia.out_norm),   64'h1000000);
        cmp("one_zero", 64'(ia.out_zero),   64'd0);
        tick();

        // Boundary operands on both instances, back to back
        for (int i = 0; i < 3; i++) begin
            ia.in_valid = 1; ia.in_data = bnd_a[i];
            ib.in_valid = 1; ib.in_data = bnd_b[i];
            tick();
        end
        ia.in_valid = 0; ib.in_valid = 0;
        repeat (4) tick();

        // Back-pressure: 5 stalled cycles, then release
        ia.out_ready = 0; ia.in_valid = 1; ia.in_data = bp[0];
        #1 cmp("bp_rdy0", 64'(ia.in_ready), 64'd1);
        tick();
        ia.in_data = bp[1];
        cmp("bp_rdy1", 64'(ia.in_ready), 64'd1);
        tick();
        ia.in_data = bp[2];
        cmp("bp_full_rdy", 64'(ia.in_ready),  64'd0);
        cmp("bp_full_ov",  64'(ia.out_valid), 64'd1);
        repeat (3) tick();
        cmp("bp_still_rdy", 64'(ia.in_ready), 64'd0);
        ia.out_ready = 1;
        k = 2;
        #1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            ia.in_data = bp[k];
            if (ia.in_ready) k++;
            tick();
        end
        ia.in_valid = 0;
        repeat (4) tick();
        cmp("bp_accepts", 64'(k), 64'd4);
        cmp("bp_drain",   64'(qa.size()), 64'd0);

        // Flush with both stages full
        ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 25'h0F0F0F0;
        tick();
        ia.in_data = 25'h0000777;
        tick();
        ia.in_data = 25'h1234567; ia.flush = 1;
        #1;
        cmp("fl_rdy",  64'(ia.in_ready),  64'd0);
        cmp("fl_full", 64'(ia.out_valid), 64'd1);
        tick();
        ia.flush = 0; ia.in_valid = 0;
        cmp("fl_ov", 64'(ia.out_valid), 64'd0);
        ia.out_ready = 1; ia.in_valid = 1; ia.in_data = 25'h0012345;
        tick();
        ia.in_valid = 0;
        cmp("fl_lat1", 64'(ia.out_valid), 64'd0);
        tick();
        cmp("fl_lat2", 64'(ia.out_valid), 64'd1);
        cmp("fl_lzc",  64'(ia.out_lzc),   64'd8);
        repeat (3) tick();
        cmp("fl_drain", 64'(qa.size()), 64'd0);

        // Reset mid-stream, away from the clock edge
        ia.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ia.in_data = 25'h0000100 << i;
            tick();
        end
        cmp("rs_busy", 64'(ia.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 cmp("rs_ov_now", 64'(ia.out_valid), 64'd0);
        ia.in_valid = 0;
        tick(); tick();
        #2 rst_n = 1'b1;
        repeat (4) tick();
        cmp("rs_quiet", 64'(ia.out_valid), 64'd0);

        // Random traffic on the 13/4 instance
        nacc = 0; cyc = 0;
        while (nacc < 10000 && cyc < 60000) begin
            ib.in_valid  = ($urandom_range(0, 3) != 0);
            ib.in_data   = 13'($urandom);
            if ($urandom_range(0, 7) == 0) ib.in_data = ib.in_data >> $urandom_range(0, 13);
            ib.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (ib.in_valid && ib.in_ready) nacc++;
            tick();
            cyc++;
        end
        cmp("rnd_count", 64'(nacc), 64'd10000);
        ib.in_valid = 0; ib.out_ready = 1;
        repeat (4) tick();
        cmp("rnd_drain", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
